// File: rtl/goertzel_ctrl.sv
// Sequencer and coefficient store for a time-multiplexed Goertzel engine:
// per-sample recurrence sweep over all bins, then a per-bin finalize/readout pass.
module goertzel_ctrl #(
  parameter int NUM_BINS  = 32,
  parameter int FRAME_LEN = 256,
  parameter int COEF_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [15:0]          s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_BINS)-1:0] cfg_addr,
  input  logic [COEF_W-1:0]           cfg_data,
  output logic                        cfg_err,
  output logic                        eng_valid,
  output logic [1:0]                  eng_op,
  output logic [$clog2(NUM_BINS)-1:0] eng_bin,
  output logic [COEF_W-1:0]           eng_coef,
  output logic signed [15:0]          eng_sample,
  input  logic [31:0]                 eng_res,
  input  logic                        eng_res_valid,
  output logic [31:0]                 out_data,
  output logic [$clog2(NUM_BINS)-1:0] out_bin,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        proto_err
);
  localparam int BIN_W = $clog2(NUM_BINS);
  localparam int SMP_W = $clog2(FRAME_LEN);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(FRAME_LEN - 1);
  localparam logic [1:0] OP_UPDATE = 2'b00;
  localparam logic [1:0] OP_FIRST  = 2'b01;
  localparam logic [1:0] OP_FINAL  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_FINAL, S_WAIT_RES, S_OUT} state_t;

  state_t                   state_reg, state_next;
  logic [BIN_W-1:0]         bin_cnt_reg;
  logic [SMP_W-1:0]         smp_cnt_reg;
  logic signed [15:0]       sample_reg;
  logic [COEF_W-1:0]        coef_reg [NUM_BINS];
  logic [31:0]              out_data_reg;
  logic [BIN_W-1:0]         out_bin_reg;
  logic                     out_last_reg;
  logic                     out_valid_reg;
  logic                     cfg_err_reg;
  logic                     proto_err_reg;
  logic                     cfg_accept;

  // Coefficients may only change between frames, while no sweep is in flight.
  assign cfg_accept = cfg_we && (state_reg == S_IDLE) && (smp_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (s_valid) state_next = S_UPDATE;
      S_UPDATE:   if (bin_cnt_reg == LAST_BIN)
                    state_next = (smp_cnt_reg == LAST_SMP) ? S_FINAL : S_IDLE;
      S_FINAL:    state_next = S_WAIT_RES;
      S_WAIT_RES: if (eng_res_valid) state_next = S_OUT;
      S_OUT:      if (out_ready) state_next = out_last_reg ? S_IDLE : S_FINAL;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state_reg == S_IDLE) && !rst;
    eng_valid = 1'b0;
    eng_op    = OP_UPDATE;
    case (state_reg)
      S_UPDATE: begin
        eng_valid = 1'b1;
        eng_op    = (smp_cnt_reg == '0) ? OP_FIRST : OP_UPDATE;
      end
      S_FINAL: begin
        eng_valid = 1'b1;
        eng_op    = OP_FINAL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt_reg   <= '0;
      smp_cnt_reg   <= '0;
      sample_reg    <= '0;
      out_data_reg  <= '0;
      out_bin_reg   <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we && !cfg_accept;
      if (eng_res_valid && state_reg != S_WAIT_RES) proto_err_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (s_valid) begin
            sample_reg  <= s_data;
            bin_cnt_reg <= '0;
          end
        end
        S_UPDATE: begin
          if (bin_cnt_reg == LAST_BIN) begin
            bin_cnt_reg <= '0;
            smp_cnt_reg <= (smp_cnt_reg == LAST_SMP) ? '0 : smp_cnt_reg + 1'b1;
          end else begin
            bin_cnt_reg <= bin_cnt_reg + 1'b1;
          end
        end
        S_WAIT_RES: begin
          if (eng_res_valid) begin
            out_data_reg  <= eng_res;
            out_bin_reg   <= bin_cnt_reg;
            out_last_reg  <= (bin_cnt_reg == LAST_BIN);
            out_valid_reg <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            bin_cnt_reg   <= out_last_reg ? '0 : bin_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BINS; i++) coef_reg[i] <= '0;
    end else if (cfg_accept) begin
      coef_reg[cfg_addr] <= cfg_data;
    end
  end

  assign eng_bin    = bin_cnt_reg;
  assign eng_coef   = coef_reg[bin_cnt_reg];
  assign eng_sample = sample_reg;
  assign out_data   = out_data_reg;
  assign out_bin    = out_bin_reg;
  assign out_last   = out_last_reg;
  assign out_valid  = out_valid_reg;
  assign cfg_err    = cfg_err_reg;
  assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_goertzel_ctrl.sv
// Directed bench for goertzel_ctrl: small 4x4 instance for sequencing/corner cases,
// full-size 32x256 instance for frame wrap and output count.
module tb_goertzel_ctrl;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // small instance
  logic signed [15:0] s_data;
  logic s_valid, s_ready, cfg_we, cfg_err, eng_valid, out_last, out_valid, out_ready, proto_err;
  logic [1:0] cfg_addr, eng_bin, out_bin, eng_op;
  logic [15:0] cfg_data, eng_coef;
  logic signed [15:0] eng_sample;
  logic [31:0] eng_res, out_data;
  logic eng_res_valid, m_res_valid, man_res_valid;
  assign eng_res_valid = m_res_valid | man_res_valid;

  goertzel_ctrl #(.NUM_BINS(NB), .FRAME_LEN(4), .COEF_W(16)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .eng_valid(eng_valid), .eng_op(eng_op), .eng_bin(eng_bin), .eng_coef(eng_coef),
    .eng_sample(eng_sample), .eng_res(eng_res), .eng_res_valid(eng_res_valid),
    .out_data(out_data), .out_bin(out_bin), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .proto_err(proto_err));

  // full-size instance
  logic signed [15:0] b_s_data, b_eng_sample;
  logic b_s_valid, b_s_ready, b_cfg_err, b_eng_valid, b_out_last, b_out_valid, b_proto_err;
  logic [4:0] b_eng_bin, b_out_bin;
  logic [1:0] b_eng_op;
  logic [15:0] b_eng_coef;
  logic [31:0] b_eng_res, b_out_data;
  logic b_eng_res_valid;

  goertzel_ctrl #(.NUM_BINS(32), .FRAME_LEN(256), .COEF_W(16)) u_big (
    .clk(clk), .rst(rst), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .cfg_we(1'b0), .cfg_addr(5'd0), .cfg_data(16'h0000), .cfg_err(b_cfg_err),
    .eng_valid(b_eng_valid), .eng_op(b_eng_op), .eng_bin(b_eng_bin), .eng_coef(b_eng_coef),
    .eng_sample(b_eng_sample), .eng_res(b_eng_res), .eng_res_valid(b_eng_res_valid),
    .out_data(b_out_data), .out_bin(b_out_bin), .out_last(b_out_last), .out_valid(b_out_valid),
    .out_ready(1'b1), .proto_err(b_proto_err));

  // Engine models: answer each FINAL with 0x1000+bin three cycles later.
  int m_cnt = 0, bm_cnt = 0;
  logic [1:0] m_bin;
  logic [4:0] bm_bin;
  always @(negedge clk) begin
    m_res_valid = 1'b0;
    if (rst) m_cnt = 0;
    else if (eng_valid && eng_op == 2'b10) begin m_cnt = 3; m_bin = eng_bin; end
    else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_res_valid = 1'b1; eng_res = 32'h1000 + 32'(m_bin); end
    end
  end
  always @(negedge clk) begin
    b_eng_res_valid = 1'b0;
    if (rst) bm_cnt = 0;
    else if (b_eng_valid && b_eng_op == 2'b10) begin bm_cnt = 3; bm_bin = b_eng_bin; end
    else if (bm_cnt > 0) begin
      bm_cnt--;
      if (bm_cnt == 0) begin b_eng_res_valid = 1'b1; b_eng_res = 32'h1000 + 32'(bm_bin); end
    end
  end

  int b_first0 = 0, b_upd = 0, b_outs = 0, b_lasts = 0;
  always @(negedge clk) begin
    if (b_eng_valid && b_eng_op == 2'b01 && b_eng_bin == 5'd0) b_first0++;
    if (b_eng_valid && b_eng_op != 2'b10) b_upd++;
    if (b_out_valid) begin b_outs++; if (b_out_last) b_lasts++; end
  end

  int n_tests = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 300) begin @(negedge clk); n++; end
    if (!s_ready) check("s_ready_timeout", 32'd0, 32'd1);
  endtask

  logic [1:0] first_op;
  logic [15:0] first_coef;
  logic first_cfg_err;
  // Accept one sample and ride out its sweep, capturing the bin-0 command.
  task automatic send_sample(input logic [15:0] d);
    wait_ready();
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    s_valid = 1'b0; cfg_we = 1'b0;
    first_op = eng_op; first_coef = eng_coef; first_cfg_err = cfg_err;
    check("sweep_bin0_valid", {31'd0, eng_valid}, 32'd1);
    repeat (NB - 1) @(negedge clk);
  endtask

  task automatic drain(output int cnt);
    cnt = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (out_last) break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] smp;
    logic [1:0]  op;
    logic [1:0]  bin;
    logic [15:0] coef;
  } vec_t;
  vec_t vec[16];
  logic [15:0] smps[4];
  logic [15:0] coefs[4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, k, nacc, nfin, nout, last_acc, fin_cyc, exp_fin, cnt;
    bit seen_ov;
    smps  = '{16'h0011, 16'h8001, 16'h7fff, 16'h0044};
    coefs = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    for (int i = 0; i < 16; i++) begin
      vec[i].smp  = smps[i / 4];
      vec[i].op   = (i < 4) ? 2'b01 : 2'b00;
      vec[i].bin  = 2'(i % 4);
      vec[i].coef = coefs[i % 4];
    end

    rst = 1'b1; s_valid = 0; s_data = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    out_ready = 1'b1; man_res_valid = 1'b0; b_s_valid = 0; b_s_data = 0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_eng_valid", {31'd0, eng_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {29'd0, cfg_err, proto_err, out_last}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 2'(i); cfg_data = coefs[i];
      @(negedge clk);
    end
    check("cfg_write_ok", {31'd0, cfg_err}, 32'd0);
    cfg_we = 1'b0;

    // Four back-to-back samples, then finalize with out_ready toggling.
    cyc = 0; k = 0; nacc = 0; nfin = 0; nout = 0; last_acc = 0; fin_cyc = 0; exp_fin = 0; seen_ov = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 300 && nout < 4; c++) begin
      if (c > 0) @(negedge clk);
      cyc++;
      if (eng_valid && eng_op != 2'b10) begin
        if (k < 16) begin
          check("upd_op", {30'd0, eng_op}, {30'd0, vec[k].op});
          check("upd_bin", {30'd0, eng_bin}, {30'd0, vec[k].bin});
          check("upd_coef", {16'd0, eng_coef}, {16'd0, vec[k].coef});
          check("upd_sample", {16'd0, eng_sample}, {16'd0, vec[k].smp});
        end
        k++;
      end
      if (eng_valid && eng_op == 2'b10) begin
        check("final_bin", {30'd0, eng_bin}, 32'(nfin));
        if (nfin == 0) begin check("final_latency", 32'(cyc - last_acc), 32'd5); fin_cyc = cyc; end
        else check("final_after_hs", 32'(cyc), 32'(exp_fin));
        nfin++;
      end
      if (out_valid) begin
        if (!seen_ov) begin check("res_latency", 32'(cyc - fin_cyc), 32'd4); seen_ov = 1; end
        check("out_data", out_data, 32'h1000 + 32'(nout));
        check("out_bin", {30'd0, out_bin}, 32'(nout));
        check("out_last", {31'd0, out_last}, (nout == 3) ? 32'd1 : 32'd0);
      end
      out_ready = ~out_ready;
      s_valid = (nacc < 4);
      s_data = smps[(nacc < 4) ? nacc : 0];
      if (s_valid && s_ready) begin
        if (nacc > 0) check("s_ready_period", 32'(cyc - last_acc), 32'd5);
        last_acc = cyc; nacc++;
      end
      if (out_valid && out_ready) begin nout++; exp_fin = cyc + 1; end
    end
    check("upd_count", 32'(k), 32'd16);
    check("out_count", 32'(nout), 32'd4);
    s_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_frame", {31'd0, s_ready}, 32'd1);
    check("no_out_after_frame", {31'd0, out_valid}, 32'd0);

    // Config write mid-frame is rejected; at frame start it lands.
    send_sample(16'h0100);
    wait_ready();
    s_valid = 1'b1; s_data = 16'h0200;
    @(negedge clk);
    s_valid = 1'b0; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'h7777;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
    @(negedge clk);
    check("cfg_err_one_cycle", {31'd0, cfg_err}, 32'd0);
    send_sample(16'h0300);
    check("cfg_rejected_coef", {16'd0, first_coef}, 32'h4000);
    check("mid_frame_op", {30'd0, first_op}, 32'd0);
    send_sample(16'h0400);
    drain(cnt);
    check("frame2_outputs", 32'(cnt), 32'd4);
    wait_ready();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'h7777;
    send_sample(16'h0500);
    check("cfg_landed_coef", {16'd0, first_coef}, 32'h7777);
    check("cfg_landed_op", {30'd0, first_op}, 32'd1);
    check("cfg_landed_no_err", {31'd0, first_cfg_err}, 32'd0);
    for (int i = 0; i < 3; i++) send_sample(16'h0600);
    drain(cnt);
    check("frame3_outputs", 32'(cnt), 32'd4);

    // Spurious engine result outside WAIT_RES.
    wait_ready();
    check("proto_err_clear", {31'd0, proto_err}, 32'd0);
    man_res_valid = 1'b1;
    @(negedge clk);
    man_res_valid = 1'b0;
    check("proto_err_set", {31'd0, proto_err}, 32'd1);
    check("spurious_no_out", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send_sample(16'h0700);
    drain(cnt);
    check("frame4_outputs", 32'(cnt), 32'd4);
    @(negedge clk);
    check("proto_err_sticky", {31'd0, proto_err}, 32'd1);

    // Reset during UPDATE of the second sample (bin 2).
    send_sample(16'h0800);
    wait_ready();
    s_valid = 1'b1; s_data = 16'h0900;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_bin2", {30'd0, eng_bin}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_upd_eng_valid", {31'd0, eng_valid}, 32'd0);
    check("rst_upd_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_clears_proto", {31'd0, proto_err}, 32'd0);
    rst = 1'b0;
    send_sample(16'h0a00);
    check("rst_upd_first", {30'd0, first_op}, 32'd1);
    check("rst_coef_zero", {16'd0, first_coef}, 32'd0);

    // Reset while holding a result in OUT.
    for (int i = 0; i < 3; i++) send_sample(16'h0b00);
    out_ready = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    check("reached_out", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_eng_valid", {31'd0, eng_valid}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    send_sample(16'h0c00);
    check("rst_out_first", {30'd0, first_op}, 32'd1);

    // Full-size frame with random gaps.
    for (int i = 0; i < 256; i++) begin
      for (int n = 0; n < 100 && !b_s_ready; n++) @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      b_s_valid = 1'b1; b_s_data = 16'($urandom);
      @(negedge clk);
      b_s_valid = 1'b0;
    end
    for (int n = 0; n < 2000 && !(b_outs == 32 && b_s_ready); n++) @(negedge clk);
    check("big_outputs", 32'(b_outs), 32'd32);
    check("big_last_count", 32'(b_lasts), 32'd1);
    check("big_first_count", 32'(b_first0), 32'd1);
    check("big_update_cmds", 32'(b_upd), 32'd8192);
    b_s_valid = 1'b1;
    @(negedge clk);
    b_s_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("big_wrap_first", 32'(b_first0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/goertzel_ctrl.md
# goertzel_ctrl

Sequencer and coefficient store for a single shared, time-multiplexed Goertzel engine in the MFCC front end. It accepts one windowed sample at a time and issues one per-bin recurrence update per cycle to the engine across all frequency bins. At frame end it runs a finalize pass that returns each bin's power, one at a time, on a valid/ready output stream. Coefficients are written through a config port and may only change on frame boundaries.

## Interface
- NUM_BINS, 32, number of frequency bins (power of two, ≥2)
- FRAME_LEN, 256, samples per frame (power of two, ≥2)
- COEF_W, 16, coefficient width (Q1.15)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- s_data  in  16  signed windowed sample
- s_valid  in  1  sample valid
- s_ready  out  1  sample accept; transfer on s_valid&&s_ready
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  $clog2(NUM_BINS)  bin index
- cfg_data  in  COEF_W  coefficient value
- cfg_err  out  1  one-cycle pulse: write rejected
- eng_valid  out  1  engine command valid (engine always accepts)
- eng_op  out  2  00 UPDATE, 01 FIRST (update with zeroed state), 10 FINAL
- eng_bin  out  $clog2(NUM_BINS)  bin addressed
- eng_coef  out  COEF_W  coefficient for eng_bin
- eng_sample  out  16  held sample
- eng_res  in  32  bin power from engine
- eng_res_valid  in  1  result strobe (only in response to FINAL)
- out_data  out  32  bin power
- out_bin  out  $clog2(NUM_BINS)  bin index of out_data
- out_last  out  1  high with the final bin of a frame
- out_valid  out  1  output valid
- out_ready  in  1  downstream accept
- proto_err  out  1  sticky: eng_res_valid seen outside WAIT_RES

## Operation
- States: IDLE, UPDATE, FINAL, WAIT_RES, OUT.
- IDLE: s_ready=1. On accept, latch s_data into eng_sample; bin counter=0; go to UPDATE.
- UPDATE: eng_valid=1, eng_bin=bin counter, eng_coef=coef[bin counter]. eng_op=FIRST if the sample counter is 0, otherwise UPDATE. Bin counter increments each cycle.
  - After bin NUM_BINS-1, the sample counter increments.
  - If the sample counter was FRAME_LEN-1, it wraps to 0, the bin counter clears, and the state goes to FINAL. Otherwise the state goes to IDLE.
- FINAL: a one-cycle eng_valid with eng_op=FINAL for the current bin; go to WAIT_RES.
- WAIT_RES: on eng_res_valid, capture eng_res into out_data and the bin counter into out_bin; set out_valid. out_last=1 if the bin is NUM_BINS-1. Go to OUT.
- OUT: hold out_* stable until out_ready.
  - On handshake: if this was the last bin, go to IDLE. Otherwise increment the bin counter and go to FINAL.
- The engine latency is arbitrary; the controller waits indefinitely in WAIT_RES.
- eng_res_valid in any state other than WAIT_RES: ignored, sets proto_err (cleared only by rst).
- Coefficient store: NUM_BINS × COEF_W registers.
  - A write is accepted only in IDLE with the sample counter at 0; it takes effect at that clock edge.
  - A write in any other condition is dropped and cfg_err pulses for 1 cycle.
- Simultaneous accepted cfg write and sample accept at frame start: the write lands first. UPDATE sees the new coefficient.
- eng_sample, eng_coef and eng_bin are don't-care when eng_valid=0. The verifier checks them only with eng_valid=1.

## Timing
- Reset (rst high at an edge):
  - Outputs and counters: state=IDLE, sample counter=0, bin counter=0.
  - Coefficient store: all coefficients = 0.
  - Cleared to 0: eng_valid, out_valid, out_last, out_data, out_bin, cfg_err and proto_err.
  - s_ready=0 while rst is high; s_ready=1 in the first cycle after release.
- rst mid-frame or mid-finalize aborts immediately with no further eng_valid or out_valid. The next sample is treated as the first of a frame (FIRST).
- Sample accepted at edge t: eng_valid is high on cycles t+1 … t+NUM_BINS, with bins 0…NUM_BINS-1 in order. s_ready returns high at t+NUM_BINS+1, giving a throughput of 1 sample per NUM_BINS+1 cycles.
- For the last frame sample, the first FINAL issues at t+NUM_BINS+1.
- eng_res_valid captured at edge r: out_valid is high from r+1.
- An out handshake at edge h with bins remaining: the next FINAL issues at cycle h+1.
- Once out_valid is asserted, out_* do not change until the handshake.
- s_ready stays 0 throughout FINAL, WAIT_RES and OUT. s_valid is ignored there.

## Test plan
- Reset check: NUM_BINS=4, FRAME_LEN=4. Write coefs 0x4000, 0x2000, 0x1000, 0x0800. Drive 4 samples back-to-back.
  - Expect 16 UPDATE-class commands: samples 1 carries FIRST on bins 0-3, samples 2-4 carry UPDATE.
  - Each command carries the correct coefficient, and s_ready has a 5-cycle period.
- Finalize with backpressure: engine model returns 0x1000+bin after 3 cycles; out_ready toggles 1/0.
  - Expect out_data 0x1000…0x1003 with out_bin 0…3, stable while stalled, and out_last only on bin 3.
  - After the last handshake, expect s_ready=1.
- Config guard: cfg_we during the second sample of a frame.
  - Expect a cfg_err pulse and no coefficient change.
  - The same write at frame start, coincident with a sample accept, lands, and bin 0 UPDATE shows the new value.
- Spurious result: pulse eng_res_valid in IDLE.
  - Expect proto_err=1, no out_valid, and proto_err still 1 after the next frame. It clears only on rst.
- Mid-operation reset: assert rst during UPDATE (bin 2) and again during OUT.
  - Expect eng_valid=0 and out_valid=0 immediately, with coefs reading 0.
  - The next sample issues FIRST.
- Long frame: FRAME_LEN=256, NUM_BINS=32, random sample gaps.
  - The sample counter wraps: FIRST appears exactly once per 256 samples.
  - Exactly 32 outputs per frame.
